// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit CPU control stage.
package cpu_pkg;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;

  // Opcode field ir[7:6]
  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  // ALU select encoding; equals op[1] for ADD/NAND
  localparam logic SEL_ADD  = 1'b0;
  localparam logic SEL_NAND = 1'b1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  // Instruction field helpers
  function automatic logic [1:0] ir_op(input logic [INSTR_W-1:0] ir);
    return ir[7:6];
  endfunction

  function automatic logic [1:0] ir_rd(input logic [INSTR_W-1:0] ir);
    return ir[5:4];
  endfunction

  function automatic logic [1:0] ir_rs(input logic [INSTR_W-1:0] ir);
    return ir[3:2];
  endfunction

  function automatic logic [DATA_W-1:0] ir_imm(input logic [INSTR_W-1:0] ir);
    return ir[3:0];
  endfunction

endpackage

// File: rtl/regfile_4x4.sv
// 4 x 4-bit register file: two asynchronous read ports, one synchronous
// write port, synchronous active-high clear. R0 is exported for debug.
module regfile_4x4
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        rd_addr_a,
  input  logic [1:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] r0
);

  logic [3:0][DATA_W-1:0] regs;

  // Register storage; reset wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (rst)     regs          <= '0;
    else if (we) regs[wr_addr] <= wr_data;
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign r0        = regs[0];

endmodule

// File: rtl/cpu_ctrl.sv
// Sequencing control for the 4-bit CPU: fetch, decode, hold ALU operands
// for ALU_WAIT_CYCLES, write back. Optional feature macro ZERO_FLAG_EN adds
// a Z flag (zero_flag port) and turns JMP with ir[4]=1 into JZ.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int                ALU_WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = 4'h0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ack,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               alu_sel,
  input  logic [DATA_W-1:0]  alu_res,
  output logic               retire,
  output logic               halted,
  output logic [DATA_W-1:0]  dbg_r0
`ifdef ZERO_FLAG_EN
  ,
  output logic               zero_flag
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(ALU_WAIT_CYCLES - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [INSTR_W-1:0]  ir;
  logic [3:0]          cnt, cnt_nxt;
  logic                ir_load, alu_load;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   rd_val, rs_val;
  logic                jmp_taken;
  logic                z_load;

  logic [1:0]          op;
  logic [DATA_W-1:0]   imm;

  assign op  = ir_op(ir);
  assign imm = ir_imm(ir);

  regfile_4x4 u_rf (
    .clk       (clk),
    .rst       (rst),
    .we        (rf_we),
    .wr_addr   (ir_rd(ir)),
    .wr_data   (rf_wdata),
    .rd_addr_a (ir_rd(ir)),
    .rd_addr_b (ir_rs(ir)),
    .rd_data_a (rd_val),
    .rd_data_b (rs_val),
    .r0        (dbg_r0)
  );

`ifdef ZERO_FLAG_EN
  logic z_q;

  // Z tracks the last ADD/NAND result written back
  always_ff @(posedge clk) begin
    if (rst)         z_q <= 1'b0;
    else if (z_load) z_q <= (rf_wdata == '0);
  end

  assign zero_flag = z_q;
  // ir[4] selects the conditional form (JZ)
  assign jmp_taken = !ir[4] || z_q;
`else
  assign jmp_taken = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state, datapath controls and retire strobe
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    ir_load   = 1'b0;
    alu_load  = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = imm;
    z_load    = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        // an ack only counts while a request is outstanding
        if (imem_req && imem_ack) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_load = 1'b1;
        case (op)
          OP_LDI: state_nxt = S_WB;
          OP_ADD, OP_NAND: begin
            cnt_nxt   = '0;
            state_nxt = S_EXEC;
          end
          default: begin
            retire = 1'b1;
            if (!jmp_taken) begin
              pc_nxt    = pc + 1'b1;
              state_nxt = S_FETCH;
            end else if (imm == pc) begin
              // jump-to-self is the halt idiom
              state_nxt = S_HALT;
            end else begin
              pc_nxt    = imm;
              state_nxt = S_FETCH;
            end
          end
        endcase
      end
      S_EXEC: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == WAIT_LAST) state_nxt = S_WB;
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_wdata  = (op == OP_LDI) ? imm : alu_res;
        z_load    = (op != OP_LDI);
        pc_nxt    = pc + 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  // PC, IR, wait counter, registered ALU operands and fetch request.
  // imem_req is registered so it is low in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= SEL_ADD;
      imem_req <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      cnt      <= cnt_nxt;
      imem_req <= (state_nxt == S_FETCH);
      if (ir_load) ir <= imem_data;
      if (alu_load) begin
        alu_a   <= rd_val;
        alu_b   <= rs_val;
        alu_sel <= op[1];
      end
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a behavioural instruction memory
// (configurable ack delay) and a combinational 4-bit ALU.
module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] imem_addr;
  logic       imem_req;
  logic [7:0] imem_data;
  logic       imem_ack;
  logic [3:0] alu_a, alu_b, alu_res;
  logic       alu_sel;
  logic       retire, halted;
  logic [3:0] dbg_r0;
`ifdef ZERO_FLAG_EN
  logic       zero_flag;
`endif

  logic [7:0] mem [16];
  int         ack_delay = 0;
  bit         spur = 1'b0;
  int         checks = 0, failures = 0;
  int         retires = 0;
  int         base;

  always #5 clk = ~clk;

  assign alu_res = alu_sel ? ~(alu_a & alu_b) : 4'(alu_a + alu_b);

  cpu_ctrl #(.ALU_WAIT_CYCLES(2), .RESET_PC(4'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_data (imem_data),
    .imem_ack  (imem_ack),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_res   (alu_res),
    .retire    (retire),
    .halted    (halted),
    .dbg_r0    (dbg_r0)
`ifdef ZERO_FLAG_EN
    ,
    .zero_flag (zero_flag)
`endif
  );

  // retire pulses, sampled mid-cycle
  always @(negedge clk) if (!rst && retire) retires <= retires + 1;

  // instruction memory responder; non-ack data is a halting JMP 0 so a
  // premature capture is visible
  initial begin
    int wc;
    wc = 0;
    imem_ack  = 1'b0;
    imem_data = 8'hC0;
    forever begin
      @(posedge clk); #2;
      if (spur) begin
        imem_ack  = 1'b1;
        imem_data = 8'hC0;
      end else if (imem_req && !rst) begin
        if (wc >= ack_delay) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          wc = 0;
        end else begin
          imem_ack  = 1'b0;
          imem_data = 8'hC0;
          wc++;
        end
      end else begin
        imem_ack  = 1'b0;
        imem_data = 8'hC0;
        wc = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    base = retires;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 16; i++) mem[i] = 8'hC0 | 8'(i);
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick;
      n++;
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic wait_ops(input string tag, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    while (!(alu_a == a && alu_b == b) && n < 200) begin
      tick;
      n++;
    end
    chk({tag, "_exec_seen"}, 32'(alu_a == a && alu_b == b), 32'd1);
  endtask

  // LDI R0,5; LDI R1,3; ADD R0,R1; JMP 3
  task automatic load_basic;
    clear_mem;
    mem[0] = 8'h05; mem[1] = 8'h13; mem[2] = 8'h44; mem[3] = 8'hC3;
  endtask

  initial begin
    // ---- reset state ----
    load_basic;
    do_reset;
    chk("rst_req",    32'(imem_req),  32'd0);
    chk("rst_addr",   32'(imem_addr), 32'h0);
    chk("rst_alu_a",  32'(alu_a),     32'h0);
    chk("rst_alu_b",  32'(alu_b),     32'h0);
    chk("rst_sel",    32'(alu_sel),   32'd0);
    chk("rst_retire", 32'(retire),    32'd0);
    chk("rst_halted", 32'(halted),    32'd0);
    chk("rst_r0",     32'(dbg_r0),    32'h0);

    // ---- basic program, ADD held for 2 cycles ----
    wait_ops("add", 4'h5, 4'h3);
    chk("add_sel_c1",    32'(alu_sel), 32'd0);
    chk("add_retire_c1", 32'(retire),  32'd0);
    tick;
    chk("add_a_c2",      32'(alu_a),   32'h5);
    chk("add_b_c2",      32'(alu_b),   32'h3);
    chk("add_sel_c2",    32'(alu_sel), 32'd0);
    chk("add_retire_c2", 32'(retire),  32'd0);
    tick;
    chk("add_wb_retire", 32'(retire),  32'd1);
    run_to_halt("basic", 100);
    chk("basic_pc",      32'(imem_addr), 32'h3);
    chk("basic_r0",      32'(dbg_r0),    32'h8);
    chk("basic_req",     32'(imem_req),  32'd0);
    tick; tick;
    chk("basic_retires", 32'(retires - base), 32'd4);

    // ---- NAND: R2=C, R3=A, R2=~(C&A)=7, then R0=R0+R2 to expose it ----
    clear_mem;
    mem[0] = 8'h2C; mem[1] = 8'h3A; mem[2] = 8'hAC; mem[3] = 8'h48; mem[4] = 8'hC4;
    do_reset;
    wait_ops("nand", 4'hC, 4'hA);
    chk("nand_sel_c1", 32'(alu_sel), 32'd1);
    tick;
    chk("nand_sel_c2", 32'(alu_sel), 32'd1);
    chk("nand_res",    32'(alu_res), 32'h7);
    run_to_halt("nand", 100);
    chk("nand_r0",     32'(dbg_r0),    32'h7);
    chk("nand_pc",     32'(imem_addr), 32'h4);
    chk("nand_retires", 32'(retires - base), 32'd5);

    // ---- overflow: F+2 = 1 ----
    clear_mem;
    mem[0] = 8'h0F; mem[1] = 8'h12; mem[2] = 8'h44; mem[3] = 8'hC3;
    do_reset;
    run_to_halt("ovf", 100);
    chk("ovf_r0", 32'(dbg_r0), 32'h1);

    // ---- PC wrap: JMP 1, LDI R0,k at k=1..F, wrap to 0 which now halts ----
    clear_mem;
    mem[0] = 8'hC1;
    for (int k = 1; k < 16; k++) mem[k] = 8'(k);
    do_reset;
    begin
      int n;
      n = 0;
      while (imem_addr != 4'h1 && n < 50) begin tick; n++; end
      chk("wrap_left0", 32'(imem_addr), 32'h1);
    end
    mem[0] = 8'hC0;
    run_to_halt("wrap", 400);
    chk("wrap_pc",      32'(imem_addr), 32'h0);
    chk("wrap_r0",      32'(dbg_r0),    32'hF);
    chk("wrap_retires", 32'(retires - base), 32'd17);

    // ---- slow memory, spurious ack in EXEC ----
    load_basic;
    ack_delay = 5;
    do_reset;
    begin
      int n;
      n = 0;
      while (!imem_req && n < 10) begin tick; n++; end
    end
    for (int k = 0; k < 5; k++) begin
      chk("slow_req_held",  32'(imem_req),  32'd1);
      chk("slow_addr_held", 32'(imem_addr), 32'h0);
      tick;
    end
    tick;
    chk("slow_req_drop", 32'(imem_req), 32'd0);
    chk("slow_no_halt",  32'(halted),   32'd0);
    wait_ops("slow_add", 4'h5, 4'h3);
    spur = 1'b1;
    tick;
    spur = 1'b0;
    run_to_halt("slow", 400);
    chk("slow_pc",      32'(imem_addr), 32'h3);
    chk("slow_r0",      32'(dbg_r0),    32'h8);
    tick; tick;
    chk("slow_retires", 32'(retires - base), 32'd4);
    ack_delay = 0;

    // ---- reset during EXEC: no writeback, fetch restarts at 0 ----
    load_basic;
    do_reset;
    wait_ops("rexec", 4'h5, 4'h3);
    chk("rexec_r0_pre", 32'(dbg_r0), 32'h5);
    rst = 1'b1;
    tick;
    chk("rexec_req",     32'(imem_req),  32'd0);
    chk("rexec_addr",    32'(imem_addr), 32'h0);
    chk("rexec_r0",      32'(dbg_r0),    32'h0);
    chk("rexec_retires", 32'(retires - base), 32'd2);
    rst = 1'b0;
    base = retires;
    tick;
    chk("rexec_req_resume",  32'(imem_req),  32'd1);
    chk("rexec_addr_resume", 32'(imem_addr), 32'h0);
    run_to_halt("rexec", 100);
    chk("rexec_r0_final", 32'(dbg_r0), 32'h8);

`ifdef ZERO_FLAG_EN
    // ---- JZ taken: F+1=0 sets Z ----
    clear_mem;
    mem[0] = 8'h0F; mem[1] = 8'h11; mem[2] = 8'h44; mem[3] = 8'hD6;
    mem[4] = 8'hC4; mem[6] = 8'hC6;
    do_reset;
    run_to_halt("jz_t", 100);
    chk("jz_t_pc", 32'(imem_addr), 32'h6);
    chk("jz_t_z",  32'(zero_flag), 32'd1);
    chk("jz_t_r0", 32'(dbg_r0),    32'h0);
    // ---- JZ not taken: F+3=2 clears Z ----
    mem[1] = 8'h13;
    do_reset;
    chk("jz_rst_z", 32'(zero_flag), 32'd0);
    run_to_halt("jz_n", 100);
    chk("jz_n_pc", 32'(imem_addr), 32'h4);
    chk("jz_n_z",  32'(zero_flag), 32'd0);
    chk("jz_n_r0", 32'(dbg_r0),    32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
